// File: rtl/mux_scan_sequencer_if.sv
// mux_scan_sequencer_if: groups the handshake and mux-select signals of the scan sequencer.
//   START, CONT      scan control from the host
//   MUX_OUT          output of the downstream 4:1 mux
//   CTRL1, CTRL2     mux select MSB/LSB
//   BUSY             sequencer is scanning or holding a snapshot
//   SNAP, SNAP_VALID, SNAP_READY   snapshot valid/ready handshake
//   SNAP_PAR         XOR of SNAP bits (only when MUX_SCAN_PARITY_EN is defined)
// Modports: master = sequencer side, slave = host/consumer/mux side.
interface mux_scan_sequencer_if;
  logic       START;
  logic       CONT;
  logic       MUX_OUT;
  logic       CTRL1;
  logic       CTRL2;
  logic       BUSY;
  logic [3:0] SNAP;
  logic       SNAP_VALID;
  logic       SNAP_READY;
`ifdef MUX_SCAN_PARITY_EN
  logic       SNAP_PAR;
`endif

  modport master (
    input  START, CONT, MUX_OUT, SNAP_READY,
`ifdef MUX_SCAN_PARITY_EN
    output SNAP_PAR,
`endif
    output CTRL1, CTRL2, BUSY, SNAP, SNAP_VALID
  );

  modport slave (
    output START, CONT, MUX_OUT, SNAP_READY,
`ifdef MUX_SCAN_PARITY_EN
    input  SNAP_PAR,
`endif
    input  CTRL1, CTRL2, BUSY, SNAP, SNAP_VALID
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps a 4:1 mux select through channels A..D, holds each
// select for DWELL cycles, samples the mux output and presents the four samples
// as one snapshot on a valid/ready handshake. Single-shot or continuous.
// Ports:
//   CLK    rising-edge clock
//   RESET  synchronous, active-high reset
//   bus    mux_scan_sequencer_if.master (START, CONT, MUX_OUT, CTRL1/2, BUSY,
//          SNAP, SNAP_VALID, SNAP_READY[, SNAP_PAR])
// Parameters: DWELL (1..255) cycles per channel, CNT_W dwell counter width.
// Optional: define MUX_SCAN_PARITY_EN to add registered SNAP_PAR = ^SNAP.
module mux_scan_sequencer #(
  parameter int DWELL = 2,
  parameter int CNT_W = 8
) (
  input logic                 CLK,
  input logic                 RESET,
  mux_scan_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  state_t           state_q;
  logic [1:0]       idx_q;
  logic [1:0]       sel_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       smp_q;   // samples A..C until D arrives
  logic [3:0]       snap_q;
  logic             vld_q;
  logic             busy_q;
`ifdef MUX_SCAN_PARITY_EN
  logic             par_q;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      sel_q   <= 2'd0;
      cnt_q   <= '0;
      smp_q   <= 3'b000;
      snap_q  <= 4'b0000;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.START) begin
            state_q <= SCAN;
            idx_q   <= 2'd0;
            sel_q   <= 2'd0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SCAN: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (idx_q == 2'd3) begin
              // D lands straight in SNAP so the whole snapshot updates at once.
              snap_q  <= {bus.MUX_OUT, smp_q};
`ifdef MUX_SCAN_PARITY_EN
              par_q   <= ^{bus.MUX_OUT, smp_q};
`endif
              vld_q   <= 1'b1;
              state_q <= DONE;
              idx_q   <= 2'd0;
              sel_q   <= 2'd0;
            end else begin
              case (idx_q)
                2'd0:    smp_q[0] <= bus.MUX_OUT;
                2'd1:    smp_q[1] <= bus.MUX_OUT;
                default: smp_q[2] <= bus.MUX_OUT;
              endcase
              idx_q <= idx_q + 2'd1;
              sel_q <= idx_q + 2'd1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.SNAP_READY) begin
            vld_q <= 1'b0;
            if (bus.CONT) begin
              state_q <= SCAN;
              idx_q   <= 2'd0;
              sel_q   <= 2'd0;
              cnt_q   <= '0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          vld_q   <= 1'b0;
          sel_q   <= 2'd0;
        end
      endcase
    end
  end

  assign bus.CTRL1      = sel_q[1];
  assign bus.CTRL2      = sel_q[0];
  assign bus.BUSY       = busy_q;
  assign bus.SNAP       = snap_q;
  assign bus.SNAP_VALID = vld_q;
`ifdef MUX_SCAN_PARITY_EN
  assign bus.SNAP_PAR   = par_q;
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: table-driven scans on a DWELL=2 instance plus
// hand-written sequences for backpressure, reset, ignored START and
// continuous mode (DWELL=1 instance). Mux is modelled behaviourally.
module tb_mux_scan_sequencer;
  localparam int DWELL_A = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] chan_a = 4'b0000;
  logic [3:0] chan_b = 4'b0000;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mux_scan_sequencer_if a ();
  mux_scan_sequencer_if b ();

  // behavioural 4:1 mux: select {CTRL1,CTRL2} picks channel index
  assign a.MUX_OUT = chan_a[{a.CTRL1, a.CTRL2}];
  assign b.MUX_OUT = chan_b[{b.CTRL1, b.CTRL2}];

  mux_scan_sequencer #(.DWELL(DWELL_A), .CNT_W(8)) dut_a (.CLK(clk), .RESET(rst), .bus(a));
  mux_scan_sequencer #(.DWELL(1),       .CNT_W(8)) dut_b (.CLK(clk), .RESET(rst), .bus(b));

  typedef struct {
    logic [3:0] ch;
    logic [3:0] snap;
    logic       par;
  } vec_t;
  vec_t vt [6];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Pulse START on dut_a, check select sequence and latency, leave at the
  // first negedge where SNAP_VALID must be high. poke pulses START mid-scan.
  task automatic do_scan(input logic [3:0] ch, input logic [3:0] exp_snap,
                         input logic exp_par, input logic poke);
    chan_a = ch;
    a.START = 1'b1;
    @(negedge clk);
    a.START = 1'b0;
    for (int k = 0; k < 4*DWELL_A; k++) begin
      chk4("scan_sel", {2'b00, a.CTRL1, a.CTRL2}, {2'b00, 2'(k / DWELL_A)});
      chk1("scan_vld_low", a.SNAP_VALID, 1'b0);
      chk1("scan_busy", a.BUSY, 1'b1);
      if (poke && k == 3) a.START = 1'b1;
      @(negedge clk);
      a.START = 1'b0;
    end
    chk1("snap_valid", a.SNAP_VALID, 1'b1);
    chk4("snap", a.SNAP, exp_snap);
    chk4("done_sel", {2'b00, a.CTRL1, a.CTRL2}, 4'b0000);
`ifdef MUX_SCAN_PARITY_EN
    chk1("snap_par", a.SNAP_PAR, exp_par);
`else
    if (exp_par === 1'bx) $display("note: parity vector undefined");
`endif
  endtask

  initial begin
    vt[0] = '{ch: 4'b1010, snap: 4'b1010, par: 1'b0};  // A=0 B=1 C=0 D=1
    vt[1] = '{ch: 4'b0011, snap: 4'b0011, par: 1'b0};  // A=1 B=1 C=0 D=0
    vt[2] = '{ch: 4'b0111, snap: 4'b0111, par: 1'b1};  // A=1 B=1 C=1 D=0
    vt[3] = '{ch: 4'b1000, snap: 4'b1000, par: 1'b1};  // only D
    vt[4] = '{ch: 4'b0000, snap: 4'b0000, par: 1'b0};
    vt[5] = '{ch: 4'b1111, snap: 4'b1111, par: 1'b0};

    a.START = 1'b0; a.CONT = 1'b0; a.SNAP_READY = 1'b1;
    b.START = 1'b0; b.CONT = 1'b0; b.SNAP_READY = 1'b1;

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk4("rst_sel", {2'b00, a.CTRL1, a.CTRL2}, 4'b0000);
    chk1("rst_busy", a.BUSY, 1'b0);
    chk4("rst_snap", a.SNAP, 4'b0000);
    chk1("rst_vld", a.SNAP_VALID, 1'b0);
    chk1("rst_vld_b", b.SNAP_VALID, 1'b0);
`ifdef MUX_SCAN_PARITY_EN
    chk1("rst_par", a.SNAP_PAR, 1'b0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // table-driven single-shot scans, accepted immediately
    for (int i = 0; i < 6; i++) begin
      do_scan(vt[i].ch, vt[i].snap, vt[i].par, 1'b0);
      @(negedge clk);
      chk1("accept_vld", a.SNAP_VALID, 1'b0);
      chk1("accept_idle", a.BUSY, 1'b0);
      chk4("snap_hold", a.SNAP, vt[i].snap);
      @(negedge clk);
    end

    // backpressure with START pokes in SCAN and DONE
    a.SNAP_READY = 1'b0;
    do_scan(4'b0011, 4'b0011, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) a.START = 1'b1;
      chk1("bp_vld", a.SNAP_VALID, 1'b1);
      chk4("bp_snap", a.SNAP, 4'b0011);
      chk1("bp_busy", a.BUSY, 1'b1);
      @(negedge clk);
      a.START = 1'b0;
    end
    a.SNAP_READY = 1'b1;
    @(negedge clk);
    chk1("bp_accept_vld", a.SNAP_VALID, 1'b0);
    chk1("bp_accept_busy", a.BUSY, 1'b0);
    for (int k = 0; k < 10; k++) begin
      chk1("no_extra_scan", a.BUSY, 1'b0);
      chk1("no_extra_vld", a.SNAP_VALID, 1'b0);
      @(negedge clk);
    end

    // reset while idx=2
    chan_a = 4'b1111;
    a.START = 1'b1;
    @(negedge clk);
    a.START = 1'b0;
    for (int k = 0; k < 4; k++) @(negedge clk);
    chk4("pre_rst_sel", {2'b00, a.CTRL1, a.CTRL2}, 4'b0010);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk4("mid_rst_sel", {2'b00, a.CTRL1, a.CTRL2}, 4'b0000);
    chk1("mid_rst_busy", a.BUSY, 1'b0);
    chk4("mid_rst_snap", a.SNAP, 4'b0000);
    chk1("mid_rst_vld", a.SNAP_VALID, 1'b0);
`ifdef MUX_SCAN_PARITY_EN
    chk1("mid_rst_par", a.SNAP_PAR, 1'b0);
`endif
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("post_rst_vld", a.SNAP_VALID, 1'b0);
    end
    do_scan(4'b0100, 4'b0100, 1'b1, 1'b0);
    @(negedge clk);
    chk1("post_rst_accept", a.SNAP_VALID, 1'b0);

    // START and RESET together: reset wins
    a.START = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    a.START = 1'b0;
    rst = 1'b0;
    chk1("rst_start_busy", a.BUSY, 1'b0);
    @(negedge clk);
    chk1("rst_start_busy2", a.BUSY, 1'b0);

    // continuous mode on DWELL=1 instance
    chan_b = 4'b1010;
    b.CONT = 1'b1;
    b.START = 1'b1;
    @(negedge clk);
    b.START = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk1("cont_vld_low", b.SNAP_VALID, 1'b0);
      @(negedge clk);
    end
    chk1("cont_vld1", b.SNAP_VALID, 1'b1);
    chk4("cont_snap1", b.SNAP, 4'b1010);
    chan_b = 4'b1101;  // A=1 B=0 C=1 D=1
    @(negedge clk);
    chk1("cont_rescan_vld", b.SNAP_VALID, 1'b0);
    chk1("cont_rescan_busy", b.BUSY, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("cont_vld_low2", b.SNAP_VALID, 1'b0);
    end
    @(negedge clk);
    chk1("cont_vld2", b.SNAP_VALID, 1'b1);
    chk4("cont_snap2", b.SNAP, 4'b1101);
`ifdef MUX_SCAN_PARITY_EN
    chk1("cont_par2", b.SNAP_PAR, 1'b1);
`endif
    b.CONT = 1'b0;
    @(negedge clk);
    chk1("cont_stop_vld", b.SNAP_VALID, 1'b0);
    chk1("cont_stop_busy", b.BUSY, 1'b0);
    chk4("cont_stop_snap", b.SNAP, 4'b1101);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
